iob_arbiter_2to1: RTL

//  Shares one IOb slave (e.g. MAC register/buffer port) between two IOb masters (e.g. CPU and

---
 rtl/iob_arbiter_2to1.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/iob_arbiter_2to1.sv
// iob_arbiter_2to1: shares one IOb slave between two IOb masters.
// Each master gets a one-entry request buffer. Grants are round-robin and only one
// slave transaction is in flight at a time. Ready/rdata are routed back to the owner.
// Optional slave response timeout is enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_arbiter_2to1 #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ready_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ready_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_address_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ready_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              pend0_q, pend0_d, pend1_q, pend1_d;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [DATA_W-1:0] wdata0_q, wdata1_q;
  logic [STRB_W-1:0] wstrb0_q, wstrb1_q;
  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;

  logic req0_s, req1_s, grant_s;
  logic ready_hit_s, to_hit_s, done_s;
  logic clr0_s, clr1_s, set0_s, set1_s;

  // A fresh request is visible to the IDLE grant in the same cycle as its valid pulse.
  assign req0_s = pend0_q | m0_valid_i;
  assign req1_s = pend1_q | m1_valid_i;

  assign ready_hit_s = (state_q == ST_BUSY) && s_ready_i;
  assign done_s      = ready_hit_s || to_hit_s;

  // Completion clears the owner's buffer; a new valid in that same cycle refills it.
  assign clr0_s = done_s && (owner_q == 1'b0);
  assign clr1_s = done_s && (owner_q == 1'b1);
  assign set0_s = m0_valid_i && (!pend0_q || clr0_s);
  assign set1_s = m1_valid_i && (!pend1_q || clr1_s);

  assign m0_ready_o = clr0_s;
  assign m1_ready_o = clr1_s;
  assign m0_rdata_o = (ready_hit_s && (owner_q == 1'b0)) ? s_rdata_i : {DATA_W{1'b0}};
  assign m1_rdata_o = (ready_hit_s && (owner_q == 1'b1)) ? s_rdata_i : {DATA_W{1'b0}};

  assign s_valid_o   = s_valid_q;
  assign s_address_o = s_address_q;
  assign s_wdata_o   = s_wdata_q;
  assign s_wstrb_o   = s_wstrb_q;
  assign busy_o      = (state_q == ST_BUSY);
  assign timeout_o   = to_hit_s;

  // Round-robin pick: on a tie the master that was not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_s && req1_s) begin
      grant_s = ~last_grant_q;
    end else if (req1_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Pending flags: set has priority over the completion clear.
  always_comb begin
    pend0_d = pend0_q;
    pend1_d = pend1_q;
    if (set0_s) begin
      pend0_d = 1'b1;
    end else if (clr0_s) begin
      pend0_d = 1'b0;
    end else begin
      pend0_d = pend0_q;
    end
    if (set1_s) begin
      pend1_d = 1'b1;
    end else if (clr1_s) begin
      pend1_d = 1'b0;
    end else begin
      pend1_d = pend1_q;
    end
  end

  // Arbitration FSM and slave-side request launch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    s_valid_d    = 1'b0;
    s_address_d  = s_address_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_s || req1_s) begin
          s_valid_d = 1'b1;
          owner_d   = grant_s;
          state_d   = ST_BUSY;
          if (grant_s == 1'b0) begin
            s_address_d = pend0_q ? addr0_q  : m0_address_i;
            s_wdata_d   = pend0_q ? wdata0_q : m0_wdata_i;
            s_wstrb_d   = pend0_q ? wstrb0_q : m0_wstrb_i;
          end else begin
            s_address_d = pend1_q ? addr1_q  : m1_address_i;
            s_wdata_d   = pend1_q ? wdata1_q : m1_wdata_i;
            s_wstrb_d   = pend1_q ? wstrb1_q : m1_wstrb_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and slave-output registers.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      s_valid_q    <= 1'b0;
      s_address_q  <= {ADDR_W{1'b0}};
      s_wdata_q    <= {DATA_W{1'b0}};
      s_wstrb_q    <= {STRB_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      s_valid_q    <= s_valid_d;
      s_address_q  <= s_address_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
    end
  end

  // Per-master request buffers, captured only when the request is accepted.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      addr0_q  <= {ADDR_W{1'b0}};
      wdata0_q <= {DATA_W{1'b0}};
      wstrb0_q <= {STRB_W{1'b0}};
      addr1_q  <= {ADDR_W{1'b0}};
      wdata1_q <= {DATA_W{1'b0}};
      wstrb1_q <= {STRB_W{1'b0}};
    end else begin
      if (set0_s) begin
        addr0_q  <= m0_address_i;
        wdata0_q <= m0_wdata_i;
        wstrb0_q <= m0_wstrb_i;
      end
      if (set1_s) begin
        addr1_q  <= m1_address_i;
        wdata1_q <= m1_wdata_i;
        wstrb1_q <= m1_wstrb_i;
      end
    end
  end

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A slave ready on the limit cycle counts as a normal completion.
  assign to_hit_s = (state_q == ST_BUSY) && !s_ready_i && (cnt_q == CNT_W'(TIMEOUT));

  // Response counter: zeroed at grant, advances every BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && (req0_s || req1_s)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_BUSY) && !done_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Response counter register.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit_s = 1'b0;
  // TIMEOUT only matters when the counter is built; referenced here so it is not dangling.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

endmodule
